// File: rtl/button_event_if.sv
// Button event bus: the debounced button level in and the event pulses and hold level out.
// The master side drives the button; the slave side is the event generator.
interface button_event_if;
  logic button_in;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic release_pulse;
  logic held;

  modport master (
    output button_in,
    input  press_pulse,
    input  short_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  release_pulse,
    input  held
  );

  modport slave (
    input  button_in,
    output press_pulse,
    output short_pulse,
    output long_pulse,
    output repeat_pulse,
    output release_pulse,
    output held
  );
endinterface

// File: rtl/button_event.sv
// Button event generator: classifies a debounced button into press, short, long,
// auto-repeat and release events using one shared hold counter.
module button_event #(
  parameter int unsigned LONG_TICKS   = 50_000_000,
  parameter int unsigned REPEAT_TICKS = 10_000_000,
  parameter int unsigned CNT_WIDTH    = 26
) (
  input  logic          clk,
  input  logic          reset,
  button_event_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESSED   = 2'd1,
    S_LONG_HELD = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_btn_q;
  logic                 r_press;
  logic                 r_short;
  logic                 r_long;
  logic                 r_repeat;
  logic                 r_release;
  logic                 r_held;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below reads the pre-edge values of r_state, r_cnt and r_btn_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      // A button held through reset must first be seen released before it can press.
      r_btn_q   <= 1'b1;
      r_press   <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_btn_q   <= bus.button_in;
      r_press   <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.button_in && !r_btn_q) begin
            r_state <= S_PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_held  <= 1'b1;
          end
        end

        S_PRESSED: begin
          // Release is tested first so it wins over a coincident terminal count.
          if (!bus.button_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_short   <= 1'b1;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end else if (r_cnt == LONG_LAST) begin
            r_state <= S_LONG_HELD;
            r_cnt   <= '0;
            r_long  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_LONG_HELD: begin
          if (!bus.button_in) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end else if (r_cnt == REPEAT_LAST) begin
            r_cnt    <= '0;
            r_repeat <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse   = r_press;
  assign bus.short_pulse   = r_short;
  assign bus.long_pulse    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.release_pulse = r_release;
  assign bus.held          = r_held;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_TICKS=8 and REPEAT_TICKS=4.
// Outputs are packed as {press, short, long, repeat, release, held}.
module tb_button_event;

  localparam int LONG_TICKS   = 8;
  localparam int REPEAT_TICKS = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  button_event_if bus ();

  button_event #(
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS),
    .CNT_WIDTH   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {bus.press_pulse, bus.short_pulse, bus.long_pulse,
            bus.repeat_pulse, bus.release_pulse, bus.held};
  endfunction

  // One edge: drive the level to be sampled, then look 1 ns after the edge.
  task automatic tick(input logic b);
    bus.button_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1;
    bus.button_in = 1'b0;
    #2 reset = 1'b0;
    #1 got = outs();
    n_checks++;
    if (got !== 6'b000000) begin
      n_errors++;
      $display("FAIL reset_async: got %b expected 000000", got);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      got = outs();
      n_checks++;
      if (got !== 6'b000000) begin
        n_errors++;
        $display("FAIL reset_held edge %0d: got %b expected 000000", i, got);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      got = outs();
      n_checks++;
      if (got !== 6'b000000) begin
        n_errors++;
        $display("FAIL reset_release edge %0d: got %b expected 000000", i, got);
      end
    end
  endtask

  task automatic test_short_press();
    logic [4:0] stim = 5'b11100;
    logic [5:0] exp_v [5] = '{6'b100001, 6'b000001, 6'b000001, 6'b010010, 6'b000000};
    logic [5:0] got;
    for (int i = 0; i < 5; i++) begin
      tick(stim[4-i]);
      got = outs();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_errors++;
        $display("FAIL short_press edge %0d: got %b expected %b", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [5:0] got;
    logic [5:0] exp_o;
    for (int i = 0; i <= 22; i++) begin
      tick(i <= 20);
      case (i)
        0:          exp_o = 6'b100001;
        8:          exp_o = 6'b001001;
        12, 16, 20: exp_o = 6'b000101;
        21:         exp_o = 6'b000010;
        22:         exp_o = 6'b000000;
        default:    exp_o = 6'b000001;
      endcase
      got = outs();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL long_repeat edge E0+%0d: got %b expected %b", i, got, exp_o);
      end
    end
  endtask

  task automatic test_release_at_long_threshold();
    logic [5:0] got;
    logic [5:0] exp_o;
    for (int i = 0; i <= 9; i++) begin
      tick(i <= 7);
      case (i)
        0:       exp_o = 6'b100001;
        8:       exp_o = 6'b010010;
        9:       exp_o = 6'b000000;
        default: exp_o = 6'b000001;
      endcase
      got = outs();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL release_at_long edge E0+%0d: got %b expected %b", i, got, exp_o);
      end
    end
  endtask

  task automatic test_release_at_repeat_threshold();
    logic [5:0] got;
    logic [5:0] exp_o;
    for (int i = 0; i <= 13; i++) begin
      tick(i <= 11);
      case (i)
        0:       exp_o = 6'b100001;
        8:       exp_o = 6'b001001;
        12:      exp_o = 6'b000010;
        13:      exp_o = 6'b000000;
        default: exp_o = 6'b000001;
      endcase
      got = outs();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL release_at_repeat edge E0+%0d: got %b expected %b", i, got, exp_o);
      end
    end
  endtask

  task automatic test_held_through_reset();
    logic [6:0] stim = 7'b1110100;
    logic [5:0] exp_v [7] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
                              6'b100001, 6'b010010, 6'b000000};
    logic [5:0] got;
    bus.button_in = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(stim[6-i]);
      got = outs();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_errors++;
        $display("FAIL held_through_reset edge %0d: got %b expected %b", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [5:0] got;
    for (int i = 0; i <= 9; i++) tick(1'b1);
    got = outs();
    n_checks++;
    if (got !== 6'b000101 && got !== 6'b000001) begin
      n_errors++;
      $display("FAIL mid_hold_pre edge E0+9: got %b expected held=1", got);
    end
    #2 reset = 1'b0;
    #1 got = outs();
    n_checks++;
    if (got !== 6'b000000) begin
      n_errors++;
      $display("FAIL mid_hold_abort: got %b expected 000000", got);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 got = outs();
      n_checks++;
      if (got !== 6'b000000) begin
        n_errors++;
        $display("FAIL mid_hold_in_reset edge %0d: got %b expected 000000", i, got);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(i < 2);
      got = outs();
      n_checks++;
      if (got !== 6'b000000) begin
        n_errors++;
        $display("FAIL mid_hold_after_reset edge %0d: got %b expected 000000", i, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] stim = 6'b101000;
    logic [5:0] exp_v [6] = '{6'b100001, 6'b010010, 6'b100001, 6'b010010,
                              6'b000000, 6'b000000};
    logic [5:0] got;
    for (int i = 0; i < 6; i++) begin
      tick(stim[5-i]);
      got = outs();
      n_checks++;
      if (got !== exp_v[i]) begin
        n_errors++;
        $display("FAIL back_to_back edge %0d: got %b expected %b", i, got, exp_v[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_long_threshold();
    test_release_at_repeat_threshold();
    test_back_to_back();
    test_held_through_reset();
    test_reset_mid_hold();
    tick(1'b0);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
